// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Behavioural SDRAM-style responder on a valid/ready memory bus. It decodes
//   ACTIVATE / READ / WRITE / PRECHARGE commands, tracks the open row for each
//   of 8 banks, and applies CAS, activation and precharge latencies.
//   Reads and writes move bursts of 8 beats at wrapping columns.
//
// Optional feature:
//   MEM_BUS_RESPONDER_REFRESH_EN -- when defined, a refresh timer closes all
//   banks every REFRESH_CYCLE cycles. The refresh is taken only in IDLE.
//
// Ports:
//   clk_in             clock, rising edge
//   rst_in             synchronous active-high reset
//   mem_bus_valid_in   initiator presents a command or a write beat
//   mem_bus_ready_out  responder accepts a command or a write beat
//   mem_bus_addr_in    [18]=cs_N [17]=act [16:14]=cmd [13:11]=bank [ROW_BITS-1:0]=row/col
//   mem_bus_value_in   write data beat
//   mem_bus_valid_out  read beat valid
//   mem_bus_ready_in   initiator accepts a read beat
//   mem_bus_value_out  read data beat
//   err_out            one-cycle protocol-error pulse
module mem_bus_responder #(
  parameter int CAS_LATENCY        = 22,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int REFRESH_CYCLE      = 5120
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        mem_bus_valid_in,
  output logic        mem_bus_ready_out,
  input  logic [18:0] mem_bus_addr_in,
  input  logic [63:0] mem_bus_value_in,
  output logic        mem_bus_valid_out,
  input  logic        mem_bus_ready_in,
  output logic [63:0] mem_bus_value_out,
  output logic        err_out
);

  // A latency of 0 behaves as 1.
  localparam int CAS_L = (CAS_LATENCY < 1) ? 1 : CAS_LATENCY;
  localparam int ACT_L = (ACTIVATION_LATENCY < 1) ? 1 : ACTIVATION_LATENCY;
  localparam int PRE_L = (PRECHARGE_LATENCY < 1) ? 1 : PRECHARGE_LATENCY;
  localparam int MAX_L0 = (CAS_L > ACT_L) ? CAS_L : ACT_L;
  localparam int MAX_L = (MAX_L0 > PRE_L) ? MAX_L0 : PRE_L;
  localparam int CNT_W = $clog2(MAX_L + 1);
  localparam int IDX_W = 3 + ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACT_WAIT, ST_PRE_WAIT, ST_RD_WAIT, ST_RD_BURST, ST_WR_WAIT, ST_WR_BURST
  } state_t;

  state_t               state_r, state_nx;
  logic [CNT_W-1:0]     cnt_r, cnt_nx;
  logic [2:0]           bank_r, bank_nx;
  logic [ROW_BITS-1:0]  row_r, row_nx;
  logic [COL_BITS-1:0]  col_r, col_nx;
  logic [2:0]           beat_r, beat_nx;
  logic [7:0]           open_r;
  logic [ROW_BITS-1:0]  open_row_r [0:7];
  logic                 valid_r, valid_nx;
  logic [63:0]          value_r;
  logic                 err_r, err_s;
  logic                 ready_r, ready_nx;
  logic [63:0]          mem_r [0:DEPTH-1];

  logic                 open_set_s, open_clr_s, clr_all_s, rd_load_s, wr_en_s;
  logic                 ref_pend_s, ref_take_s, ref_expire_s, ref_pend_nx_s;
  logic [IDX_W-1:0]     rd_idx_s, wr_idx_s;

  // Command field decode.
  logic                 cmd_cs_n_s, cmd_act_s;
  logic [2:0]           cmd_op_s, cmd_bank_s;
  logic [ROW_BITS-1:0]  cmd_row_s;
  logic [COL_BITS-1:0]  cmd_col_s;
  logic                 unused_addr_s;

  assign cmd_cs_n_s    = mem_bus_addr_in[18];
  assign cmd_act_s     = mem_bus_addr_in[17];
  assign cmd_op_s      = mem_bus_addr_in[16:14];
  assign cmd_bank_s    = mem_bus_addr_in[13:11];
  assign cmd_row_s     = mem_bus_addr_in[ROW_BITS-1:0];
  assign cmd_col_s     = mem_bus_addr_in[COL_BITS-1:0];
  assign unused_addr_s = ^mem_bus_addr_in;

  assign rd_idx_s = {bank_nx, row_nx, col_nx};
  assign wr_idx_s = {bank_r, row_r, col_r};

  assign mem_bus_ready_out = ready_r;
  assign mem_bus_valid_out = valid_r;
  assign mem_bus_value_out = value_r;
  assign err_out           = err_r;

`ifdef MEM_BUS_RESPONDER_REFRESH_EN
  localparam int REF_W = $clog2(REFRESH_CYCLE + 1);
  logic [REF_W-1:0] ref_cnt_r;
  logic             ref_pend_r;

  assign ref_expire_s = (ref_cnt_r == REF_W'(REFRESH_CYCLE - 1));
  assign ref_pend_s   = ref_pend_r;

  // Free-running refresh timer; an expiry stays pending until IDLE takes it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ref_cnt_r  <= '0;
      ref_pend_r <= 1'b0;
    end else begin
      ref_cnt_r  <= ref_expire_s ? '0 : ref_cnt_r + REF_W'(1);
      ref_pend_r <= ref_pend_nx_s;
    end
  end
`else
  assign ref_expire_s = 1'b0;
  assign ref_pend_s   = 1'b0;
`endif

  assign ref_pend_nx_s = (ref_pend_s & ~ref_take_s) | ref_expire_s;

  // Next-state, bank bookkeeping and beat sequencing.
  always_comb begin
    state_nx   = state_r;
    cnt_nx     = cnt_r;
    bank_nx    = bank_r;
    row_nx     = row_r;
    col_nx     = col_r;
    beat_nx    = beat_r;
    valid_nx   = valid_r;
    err_s      = 1'b0;
    open_set_s = 1'b0;
    open_clr_s = 1'b0;
    clr_all_s  = 1'b0;
    rd_load_s  = 1'b0;
    wr_en_s    = 1'b0;
    ref_take_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ref_pend_s) begin
          // Refresh wins over any command presented in the same cycle.
          ref_take_s = 1'b1;
          clr_all_s  = 1'b1;
          state_nx   = ST_PRE_WAIT;
          cnt_nx     = CNT_W'(PRE_L);
        end else if (mem_bus_valid_in && ready_r && !cmd_cs_n_s) begin
          if (cmd_act_s) begin
            if (open_r[cmd_bank_s]) begin
              err_s = 1'b1;
            end else begin
              open_set_s = 1'b1;
              state_nx   = ST_ACT_WAIT;
              cnt_nx     = CNT_W'(ACT_L);
            end
          end else begin
            case (cmd_op_s)
              3'b101, 3'b100: begin
                if (!open_r[cmd_bank_s]) begin
                  err_s = 1'b1;
                end else begin
                  bank_nx = cmd_bank_s;
                  row_nx  = open_row_r[cmd_bank_s];
                  col_nx  = cmd_col_s;
                  beat_nx = 3'd0;
                  // The wait state lasts CAS-1 cycles so the first beat
                  // (or ready) lands exactly CAS cycles after accept.
                  cnt_nx  = CNT_W'(CAS_L - 1);
                  if (cmd_op_s == 3'b101) begin
                    if (CAS_L == 1) begin
                      state_nx  = ST_RD_BURST;
                      rd_load_s = 1'b1;
                      valid_nx  = 1'b1;
                    end else begin
                      state_nx = ST_RD_WAIT;
                    end
                  end else begin
                    state_nx = (CAS_L == 1) ? ST_WR_BURST : ST_WR_WAIT;
                  end
                end
              end
              3'b010: begin
                open_clr_s = 1'b1;
                state_nx   = ST_PRE_WAIT;
                cnt_nx     = CNT_W'(PRE_L);
              end
              default: err_s = 1'b1;
            endcase
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ACT_WAIT, ST_PRE_WAIT, ST_WR_WAIT: begin
        if (cnt_r <= CNT_W'(1)) begin
          state_nx = (state_r == ST_WR_WAIT) ? ST_WR_BURST : ST_IDLE;
        end else begin
          cnt_nx = cnt_r - CNT_W'(1);
        end
      end
      ST_RD_WAIT: begin
        if (cnt_r <= CNT_W'(1)) begin
          state_nx  = ST_RD_BURST;
          rd_load_s = 1'b1;
          valid_nx  = 1'b1;
        end else begin
          cnt_nx = cnt_r - CNT_W'(1);
        end
      end
      ST_RD_BURST: begin
        if (valid_r && mem_bus_ready_in) begin
          if (beat_r == 3'd7) begin
            state_nx = ST_IDLE;
            valid_nx = 1'b0;
          end else begin
            beat_nx   = beat_r + 3'd1;
            col_nx    = col_r + COL_BITS'(1);
            rd_load_s = 1'b1;
          end
        end else begin
          valid_nx = valid_r;
        end
      end
      ST_WR_BURST: begin
        if (mem_bus_valid_in && ready_r) begin
          wr_en_s = 1'b1;
          col_nx  = col_r + COL_BITS'(1);
          beat_nx = beat_r + 3'd1;
          if (beat_r == 3'd7) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_WR_BURST;
          end
        end else begin
          state_nx = ST_WR_BURST;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // Ready drops in IDLE while a refresh is pending so no command is lost.
    ready_nx = ((state_nx == ST_IDLE) && !ref_pend_nx_s) || (state_nx == ST_WR_BURST);
  end

  // State, bank table and registered bus outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      bank_r  <= 3'd0;
      row_r   <= '0;
      col_r   <= '0;
      beat_r  <= 3'd0;
      open_r  <= 8'h00;
      for (int i = 0; i < 8; i++) open_row_r[i] <= '0;
      valid_r <= 1'b0;
      value_r <= 64'h0;
      err_r   <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      bank_r  <= bank_nx;
      row_r   <= row_nx;
      col_r   <= col_nx;
      beat_r  <= beat_nx;
      if (clr_all_s) open_r <= 8'h00;
      else if (open_set_s) open_r[cmd_bank_s] <= 1'b1;
      else if (open_clr_s) open_r[cmd_bank_s] <= 1'b0;
      if (open_set_s) open_row_r[cmd_bank_s] <= cmd_row_s;
      valid_r <= valid_nx;
      if (rd_load_s) value_r <= mem_r[rd_idx_s];
      err_r   <= err_s;
      ready_r <= ready_nx;
    end
  end

  // Data array; deliberately not touched by reset so contents survive it.
  always_ff @(posedge clk_in) begin
    if (wr_en_s && !rst_in) mem_r[wr_idx_s] <= mem_bus_value_in;
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: a reference memory model feeds a
// queue of expected read beats, and a negedge monitor pops and compares every
// transferred beat and checks that stalled beats hold.
module tb_mem_bus_responder;

  localparam int CAS = 22;
  localparam int ACT = 8;
  localparam int PRE = 5;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        mem_bus_valid_in;
  logic        mem_bus_ready_out;
  logic [18:0] mem_bus_addr_in;
  logic [63:0] mem_bus_value_in;
  logic        mem_bus_valid_out;
  logic        mem_bus_ready_in;
  logic [63:0] mem_bus_value_out;
  logic        err_out;

  mem_bus_responder dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .mem_bus_valid_in  (mem_bus_valid_in),
    .mem_bus_ready_out (mem_bus_ready_out),
    .mem_bus_addr_in   (mem_bus_addr_in),
    .mem_bus_value_in  (mem_bus_value_in),
    .mem_bus_valid_out (mem_bus_valid_out),
    .mem_bus_ready_in  (mem_bus_ready_in),
    .mem_bus_value_out (mem_bus_value_out),
    .err_out           (err_out)
  );

  always #5 clk_in = ~clk_in;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          beats_seen = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_mem [int];
  logic        hold_pend = 1'b0;
  logic [63:0] hold_v = 64'h0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] mk_addr(input logic act, input logic [2:0] op,
                                          input logic [2:0] bank, input logic [7:0] rc);
    return {1'b0, act, op, bank, 3'b000, rc};
  endfunction

  function automatic int midx(input logic [2:0] b, input logic [7:0] r, input logic [3:0] c);
    return (int'(b) << 12) | (int'(r) << 4) | int'(c);
  endfunction

  function automatic logic [63:0] model_rd(input int i);
    if (model_mem.exists(i)) return model_mem[i];
    else return 64'h0;
  endfunction

  always @(posedge clk_in) cyc <= cyc + 1;

  // Read-beat monitor: compare each transfer, check stalled beats stay put.
  always @(negedge clk_in) begin
    if (!rst_in && mem_bus_valid_out) begin
      if (hold_pend) check_eq("hold_val", mem_bus_value_out, hold_v);
      if (mem_bus_ready_in) begin
        if (exp_q.size() == 0) check_eq("unexp_beat", mem_bus_valid_out, 1'b0);
        else check_eq("rd_data", mem_bus_value_out, exp_q.pop_front());
        beats_seen++;
        hold_pend = 1'b0;
      end else begin
        hold_pend = 1'b1;
        hold_v    = mem_bus_value_out;
      end
    end else begin
      if (hold_pend && !rst_in) check_eq("hold_vld", mem_bus_valid_out, 1'b1);
      hold_pend = 1'b0;
    end
  end

  task automatic issue(input logic [18:0] a, output int acc);
    acc = -1;
    @(posedge clk_in); #2;
    mem_bus_valid_in = 1'b1;
    mem_bus_addr_in  = a;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_in);
      if (mem_bus_ready_out) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check_eq("cmd_accept", mem_bus_ready_out, 1'b1);
    @(posedge clk_in); #2;
    mem_bus_valid_in = 1'b0;
    mem_bus_addr_in  = 19'h40000;
  endtask

  task automatic wait_ready(input string tag, input int acc, input int exp_lat);
    int seen = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk_in);
      if (mem_bus_ready_out) begin
        seen = cyc;
        break;
      end
    end
    check_eq(tag, 64'(seen - acc), 64'(exp_lat));
  endtask

  // Ready returns one cycle after the last of ACT busy cycles.
  task automatic do_act(input logic [2:0] b, input logic [7:0] r);
    int acc;
    issue(mk_addr(1'b1, 3'b000, b, r), acc);
    wait_ready("act_busy", acc, ACT + 1);
  endtask

  task automatic do_write(input logic [2:0] b, input logic [7:0] r, input logic [3:0] c,
                          input logic [63:0] base);
    int acc;
    issue(mk_addr(1'b0, 3'b100, b, {4'h0, c}), acc);
    wait_ready("wr_lat", acc, CAS);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_in); #2;
      mem_bus_valid_in = 1'b1;
      mem_bus_value_in = base + 64'(i);
      @(negedge clk_in);
      check_eq("wr_ready", mem_bus_ready_out, 1'b1);
      model_mem[midx(b, r, 4'(c + 4'(i)))] = base + 64'(i);
    end
    @(posedge clk_in); #2;
    mem_bus_valid_in = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] b, input logic [7:0] r, input logic [3:0] c,
                         input logic stall);
    int acc;
    int first = -1;
    int start;
    for (int i = 0; i < 8; i++) exp_q.push_back(model_rd(midx(b, r, 4'(c + 4'(i)))));
    start = beats_seen;
    issue(mk_addr(1'b0, 3'b101, b, {4'h0, c}), acc);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk_in); #1;
      if (mem_bus_valid_out) begin
        first = cyc;
        break;
      end
    end
    check_eq("rd_lat", 64'(first - acc), 64'(CAS));
    for (int i = 1; i < 60 && beats_seen < start + 8; i++) begin
      @(posedge clk_in); #2;
      mem_bus_ready_in = (stall && i >= 2 && i <= 4) ? 1'b0 : 1'b1;
      @(negedge clk_in); #1;
    end
    check_eq("rd_beats", 64'(beats_seen - start), 64'd8);
    check_eq("rd_q_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk_in);
    check_eq("rd_end_vld", mem_bus_valid_out, 1'b0);
    check_eq("rd_end_rdy", mem_bus_ready_out, 1'b1);
  endtask

  task automatic issue_err(input logic [18:0] a, input string tag);
    int acc;
    issue(a, acc);
    @(negedge clk_in);
    check_eq({tag, "_err"}, err_out, 1'b1);
    check_eq({tag, "_rdy"}, mem_bus_ready_out, 1'b1);
    @(negedge clk_in);
    check_eq({tag, "_err1"}, err_out, 1'b0);
  endtask

  task automatic count_valid(input string tag, input int n);
    int seen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_in);
      if (mem_bus_valid_out) seen++;
    end
    check_eq(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int start;
    logic [18:0] a;
    rst_in           = 1'b1;
    mem_bus_valid_in = 1'b0;
    mem_bus_addr_in  = 19'h40000;
    mem_bus_value_in = 64'h0;
    mem_bus_ready_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_eq("rst_valid", mem_bus_valid_out, 1'b0);
    check_eq("rst_value", mem_bus_value_out, 64'h0);
    check_eq("rst_err", err_out, 1'b0);
    check_eq("rst_ready", mem_bus_ready_out, 1'b1);
    @(posedge clk_in); #2;
    rst_in = 1'b0;

    // Basic write/read, then a wrapping burst, then a stalled read.
    do_act(3'd2, 8'd5);
    do_write(3'd2, 8'd5, 4'd0, 64'd1);
    do_read(3'd2, 8'd5, 4'd0, 1'b0);
    do_write(3'd2, 8'd5, 4'd14, 64'hA0);
    do_read(3'd2, 8'd5, 4'd14, 1'b0);
    do_read(3'd2, 8'd5, 4'd0, 1'b1);

    // ACTIVATE to an open bank errors and leaves its row alone.
    issue_err(mk_addr(1'b1, 3'b000, 3'd2, 8'd9), "act_open");
    do_read(3'd2, 8'd5, 4'd0, 1'b0);

    // PRECHARGE of a closed bank is legal.
    issue(mk_addr(1'b0, 3'b010, 3'd4, 8'd0), acc);
    @(negedge clk_in);
    check_eq("pre_noerr", err_out, 1'b0);
    wait_ready("pre_busy", acc, PRE + 1);

    issue_err(mk_addr(1'b0, 3'b101, 3'd1, 8'd0), "rd_closed");
    count_valid("rd_closed_vld", 30);
    issue_err(mk_addr(1'b0, 3'b111, 3'd2, 8'd0), "bad_cmd");

    // cs_N high: an ACTIVATE on bank 3 must be ignored.
    a = mk_addr(1'b1, 3'b000, 3'd3, 8'd1);
    a[18] = 1'b1;
    @(posedge clk_in); #2;
    mem_bus_valid_in = 1'b1;
    mem_bus_addr_in  = a;
    @(posedge clk_in); #2;
    mem_bus_valid_in = 1'b0;
    mem_bus_addr_in  = 19'h40000;
    @(negedge clk_in);
    check_eq("cs_err", err_out, 1'b0);
    check_eq("cs_rdy", mem_bus_ready_out, 1'b1);
    issue_err(mk_addr(1'b0, 3'b101, 3'd3, 8'd0), "cs_closed");

    // Reset while the 4th read beat is on the bus.
    for (int i = 0; i < 8; i++) exp_q.push_back(model_rd(midx(3'd2, 8'd5, 4'(i))));
    start = beats_seen;
    issue(mk_addr(1'b0, 3'b101, 3'd2, 8'd0), acc);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk_in); #1;
      if (beats_seen >= start + 3) break;
    end
    check_eq("rst_pre_beats", 64'(beats_seen - start), 64'd3);
    @(posedge clk_in); #2;
    mem_bus_ready_in = 1'b0;
    rst_in           = 1'b1;
    @(negedge clk_in);
    check_eq("rst_beat4", mem_bus_value_out, model_rd(midx(3'd2, 8'd5, 4'd3)));
    @(posedge clk_in); #2;
    rst_in           = 1'b0;
    mem_bus_ready_in = 1'b1;
    exp_q.delete();
    @(negedge clk_in);
    check_eq("mid_rst_valid", mem_bus_valid_out, 1'b0);
    check_eq("mid_rst_value", mem_bus_value_out, 64'h0);
    check_eq("mid_rst_ready", mem_bus_ready_out, 1'b1);
    count_valid("mid_rst_quiet", 30);
    issue_err(mk_addr(1'b0, 3'b101, 3'd2, 8'd0), "rd_after_rst");
    do_act(3'd2, 8'd5);
    do_read(3'd2, 8'd5, 4'd0, 1'b0);

`ifdef MEM_BUS_RESPONDER_REFRESH_EN
    repeat (5200) @(posedge clk_in);
    issue_err(mk_addr(1'b0, 3'b101, 3'd2, 8'd0), "rd_refresh");
`endif

    repeat (5) @(posedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
